// File: rtl/cpu_control_fsm.sv
// Control sequencer for the Simple RISC Machine: fetch, decode, execute, memory and write-back.
// State updates on the falling clock edge so the datapath captures on the rising edge in between.
module cpu_control_fsm #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       load_pc,
    output logic       reset_pc,
    output logic [1:0] pc_sel,
    output logic       loadir,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic       halted,
    output logic [4:0] dbg_state,
    output logic [3:0] dbg_wcnt
);

    typedef enum logic [4:0] {
        S_RST  = 5'd0,
        S_IF1  = 5'd1,
        S_IF2  = 5'd2,
        S_UPC  = 5'd3,
        S_DEC  = 5'd4,
        S_WIMM = 5'd5,
        S_GETA = 5'd6,
        S_GETB = 5'd7,
        S_ALU  = 5'd8,
        S_WRC  = 5'd9,
        S_ADDR = 5'd10,
        S_MWR  = 5'd11,
        S_MRD  = 5'd12,
        S_MWB  = 5'd13,
        S_BR   = 5'd14,
        S_BLW  = 5'd15,
        S_BLJ  = 5'd16,
        S_BXB  = 5'd17,
        S_BXC  = 5'd18,
        S_BXP  = 5'd19,
        S_HALT = 5'd20
    } state_t;

    localparam logic [1:0] MEM_WRITE = 2'b01;
    localparam logic [1:0] MEM_READ  = 2'b11;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;
    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_PC   = 2'b01;
    localparam logic [1:0] VSEL_IMM  = 2'b10;
    localparam logic [1:0] VSEL_MD   = 2'b11;
    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_REL    = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       is_cmp;
    logic       is_mem;
    logic       take;

    assign is_cmp    = (opcode == 3'b101) && (op == 2'b01);
    assign is_mem    = (opcode == 3'b011) || (opcode == 3'b100);
    assign dbg_state = state_q;
    assign dbg_wcnt  = wcnt_q;

    always_comb begin
        take = 1'b0;
        case (cond)
            3'b000:  take = 1'b1;
            3'b001:  take = Z;
            3'b010:  take = ~Z;
            3'b011:  take = N ^ V;
            3'b100:  take = (N ^ V) | Z;
            default: take = 1'b0;
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= S_RST;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        nsel      = 3'b000;
        vsel      = VSEL_C;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        pc_sel    = PC_INC;
        loadir    = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = 2'b00;
        halted    = 1'b0;

        case (state_q)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
                state_d  = S_IF1;
            end
            S_IF1: begin
                mem_cmd  = MEM_READ;
                addr_sel = 1'b1;
                if (wcnt_q == 4'd0) state_d = S_IF2;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            S_IF2: begin
                mem_cmd  = MEM_READ;
                addr_sel = 1'b1;
                loadir   = 1'b1;
                state_d  = S_UPC;
            end
            S_UPC: begin
                load_pc = 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                // Undecoded encodings fall back to fetch so the machine never wedges.
                case (opcode)
                    3'b110: begin
                        if (op == 2'b10)      state_d = S_WIMM;
                        else if (op == 2'b00) state_d = S_GETA;
                        else                  state_d = S_IF1;
                    end
                    3'b101, 3'b011, 3'b100: state_d = S_GETA;
                    3'b001: state_d = S_BR;
                    3'b010: begin
                        case (op)
                            2'b11, 2'b10: state_d = S_BLW;
                            2'b00:        state_d = S_BXB;
                            default:      state_d = S_IF1;
                        endcase
                    end
                    3'b111:  state_d = S_HALT;
                    default: state_d = S_IF1;
                endcase
            end
            S_WIMM: begin
                nsel    = NSEL_RN;
                vsel    = VSEL_IMM;
                write   = 1'b1;
                state_d = S_IF1;
            end
            S_GETA: begin
                nsel    = NSEL_RN;
                loada   = 1'b1;
                state_d = S_GETB;
            end
            S_GETB: begin
                loadb   = 1'b1;
                nsel    = (opcode == 3'b100) ? NSEL_RD : NSEL_RM;
                state_d = S_ALU;
            end
            S_ALU: begin
                loadc   = 1'b1;
                nsel    = NSEL_RM;
                asel    = (opcode == 3'b110);
                bsel    = is_mem;
                loads   = is_cmp;
                state_d = is_mem ? S_ADDR : S_WRC;
            end
            S_WRC: begin
                nsel    = NSEL_RD;
                vsel    = VSEL_C;
                write   = ~is_cmp;
                state_d = S_IF1;
            end
            S_ADDR: begin
                // For a store, C is reloaded with Rd so it can drive the write data.
                load_addr = 1'b1;
                asel      = (opcode == 3'b100);
                loadc     = (opcode == 3'b100);
                state_d   = (opcode == 3'b100) ? S_MWR : S_MRD;
            end
            S_MWR: begin
                mem_cmd = MEM_WRITE;
                if (wcnt_q == 4'd0) state_d = S_IF1;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            S_MRD: begin
                mem_cmd = MEM_READ;
                if (wcnt_q == 4'd0) state_d = S_MWB;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            S_MWB: begin
                mem_cmd = MEM_READ;
                nsel    = NSEL_RD;
                vsel    = VSEL_MD;
                write   = 1'b1;
                state_d = S_IF1;
            end
            S_BR: begin
                load_pc = take;
                pc_sel  = PC_REL;
                state_d = S_IF1;
            end
            S_BLW: begin
                nsel    = NSEL_RN;
                vsel    = VSEL_PC;
                write   = 1'b1;
                state_d = (op == 2'b11) ? S_BLJ : S_BXB;
            end
            S_BLJ: begin
                load_pc = 1'b1;
                pc_sel  = PC_REL;
                state_d = S_IF1;
            end
            S_BXB: begin
                nsel    = NSEL_RD;
                loadb   = 1'b1;
                state_d = S_BXC;
            end
            S_BXC: begin
                asel    = 1'b1;
                loadc   = 1'b1;
                state_d = S_BXP;
            end
            S_BXP: begin
                load_pc = 1'b1;
                pc_sel  = PC_REG;
                state_d = S_IF1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_RST;
                wcnt_d  = 4'd0;
            end
        endcase

        // The wait counter is preloaded whenever a memory-holding state is entered.
        if ((state_d != state_q) &&
            ((state_d == S_IF1) || (state_d == S_MRD) || (state_d == S_MWR))) begin
            wcnt_d = WAIT_INIT;
        end
    end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Parametrised next-generation control FSM for the Simple RISC Machine CPU. It sequences fetch, decode, execute, memory and write-back by driving the datapath, register file, PC and memory-interface controls from the instruction register fields and status flags. Beyond the baseline instruction set it adds conditional branches, call and return, and a configurable number of memory wait cycles. Undecoded opcodes are skipped rather than wedging the machine.

## Interface
- `MEM_WAIT`, default 0: extra cycles that every memory read or write is held (0–15).
- `clk` in 1: clock. The state register updates on the falling edge, so the datapath captures on the rising edge in between.
- `reset` in 1: synchronous, active-high, sampled on the falling edge of `clk`.
- `opcode` in 3: IR[15:13].
- `op` in 2: IR[12:11].
- `cond` in 3: IR[10:8], the branch condition.
- `N`, `V`, `Z` in 1 each: status flags from the status register.
- `nsel` out 3: one-hot register select. 100 selects Rn, 010 selects Rd, 001 selects Rm.
- `vsel` out 2: write-back source. 00 is C, 01 is PC, 10 is sx(im8), 11 is mdata.
- `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel` out 1 each: datapath controls.
- `load_pc`, `reset_pc` out 1 each: PC controls.
- `pc_sel` out 2: next-PC source. 00 is PC+1, 01 is PC+sx(im8), 10 is datapath C.
- `loadir`, `load_addr`, `addr_sel` out 1 each: IR, data-address and address-mux controls. `addr_sel=1` selects the PC.
- `mem_cmd` out 2: memory command. 00 is NONE, 01 is WRITE, 11 is READ.
- `halted` out 1: high while in HALT.

## Operation
- Encoding is a 5-bit state register. A 4-bit `wcnt` counts wait cycles.
- Outputs are a function of state, plus the IR fields and flags where listed below. Any control not listed for a state is 0, and `mem_cmd` is NONE.

States and outputs:
- RST: `reset_pc=1`, `load_pc=1`, `pc_sel=00`. Next state is IF1.
- IF1: `mem_cmd=READ`, `addr_sel=1`. Held for MEM_WAIT+1 cycles, then IF2.
- IF2: `mem_cmd=READ`, `addr_sel=1`, `loadir=1`. Next state is UPC.
- UPC: `load_pc=1`, `pc_sel=00`. Next state is DEC.
- DEC: no outputs. Next state depends on the decoded instruction:
  - opcode 110 with op 10 → WIMM.
  - opcode 101, 011, 100, or 110 with op 00 → GETA.
  - opcode 001 → BR.
  - opcode 010: op 11 → BLW; op 00 → BXB; op 10 → BLW.
  - opcode 111 → HALT.
  - Any other code → IF1 (treated as a NOP).
- WIMM: `nsel=100`, `vsel=10`, `write=1`. Next state is IF1.
- GETA: `nsel=100`, `loada=1`. Next state is GETB.
- GETB: `loadb=1`. `nsel=010` when opcode is 100, otherwise `nsel=001`. Next state is ALU.
- ALU: `loadc=1`, `nsel=001`.
  - `asel=1` when opcode is 110.
  - `bsel=1` when opcode is 011 or 100.
  - `loads=1` only when opcode is 101 and op is 01 (CMP).
  - Next state is ADDR for opcode 011/100, otherwise WRC.
- WRC: `nsel=010`, `vsel=00`. `write=1` unless the instruction is CMP. Next state is IF1.
- ADDR: `load_addr=1`. When opcode is 100, also `asel=1`, `loadc=1` (C ← Rd). Next state is MWR for opcode 100, otherwise MRD.
- MWR: `mem_cmd=WRITE`. Held for MEM_WAIT+1 cycles, then IF1.
- MRD: `mem_cmd=READ`. Held for MEM_WAIT+1 cycles, then MWB.
- MWB: `mem_cmd=READ`, `nsel=010`, `vsel=11`, `write=1`. Next state is IF1.
- BR: `load_pc=take`, `pc_sel=01`. Next state is IF1. `take` is decoded from `cond`:
  - 000 → 1
  - 001 → Z
  - 010 → !Z
  - 011 → N^V
  - 100 → (N^V)|Z
  - any other value → 0
- BLW: `nsel=100`, `vsel=01`, `write=1` (writes R7 ← PC). Next state is BLJ for op 11, BXB for op 10.
- BLJ: `load_pc=1`, `pc_sel=01`. Next state is IF1.
- BXB: `nsel=010`, `loadb=1`. Next state is BXC.
- BXC: `asel=1`, `loadc=1` (C ← Rd). Next state is BXP.
- BXP: `load_pc=1`, `pc_sel=10`. Next state is IF1.
- HALT: `halted=1`. Stays in HALT until `reset`.

Rules:
- PC already holds PC+1 after UPC, so branch targets are (PC+1)+sx(im8), as the ISA requires.
- `wcnt` loads MEM_WAIT on entry to IF1, MRD or MWR, and decrements each cycle. The state exits when `wcnt` reaches 0.
- An unreachable state encoding goes to RST on the next edge, with all outputs 0 in that cycle.

## Timing
- Reset has priority over every transition, from any state including mid-instruction, mid-wait and HALT. On the next falling edge the state becomes RST and `wcnt` becomes 0.
- Output values in RST: `reset_pc=1`, `load_pc=1`, `pc_sel=00`, `mem_cmd=00`, `halted=0`, and every other output 0.
- Instruction cycle counts from IF1 entry to the next IF1, with W=MEM_WAIT:
  - MOV imm: 5+W
  - NOP: 4+W
  - ALU/MOV reg/CMP: 8+W
  - STR: 9+2W
  - LDR: 10+2W
  - B (taken or not): 5+W
  - BL: 6+W
  - BX: 7+W
  - BLX: 8+W
- Flags are sampled combinationally during BR. They reflect the most recent CMP, since flags only load in the ALU state.
- `mem_cmd` stays READ continuously across IF1→IF2 and MRD→MWB. Read data is therefore stable when `loadir` or `write` is asserted.

## Test plan
- Reset, then release with MEM_WAIT=0 → RST for one cycle (`reset_pc=1`, `load_pc=1`), then IF1 with `mem_cmd=11`, `addr_sel=1`. MOV R0,#5 completes in 5 cycles with `vsel=10`, `nsel=100`, `write=1` in WIMM.
- CMP R1,R2 with R1=R2 (Z=1), then BEQ -3 → `loads=1` only in ALU, `write=0` in WRC. In BR, `load_pc=1`, `pc_sel=01`. Repeat with BNE → `load_pc=0` and the next fetch is sequential.
- BL +4 at PC=10 → BLW writes R7=11 (`vsel=01`, `nsel=100`), BLJ loads PC=15. A following BX R7 asserts `pc_sel=10`, `load_pc=1` in BXP.
- MEM_WAIT=2: LDR R3,[R1,#2] → IF1 held 3 cycles, MRD held 3 cycles, MWB with `vsel=11`, `write=1`. Total 14 cycles.
- STR with MEM_WAIT=0 → ADDR asserts `load_addr=1`, `asel=1`, `loadc=1`. MWR asserts `mem_cmd=01` for exactly 1 cycle.
- Reset asserted during the second MRD wait cycle → next state RST, `wcnt=0`. After HALT (`halted=1` for 20 cycles), reset returns to RST.
